// File: rtl/vga_sync_receiver_if.sv
// Link-side bundle of the VGA sink: sampled sync/RGB inputs toward the receiver
// and the recovered pixel stream, lock and error status coming back.
interface vga_sync_receiver_if;
  logic        pixEn;
  logic        hSync;
  logic        vSync;
  logic [11:0] rgbIn;
  logic [9:0]  x;
  logic [8:0]  y;
  logic [11:0] pixel;
  logic        pixValid;
  logic        frameStart;
  logic        locked;
  logic        timingErr;
  logic [15:0] errCount;

  modport master (
    output pixEn, hSync, vSync, rgbIn,
    input  x, y, pixel, pixValid, frameStart, locked, timingErr, errCount
  );

  modport slave (
    input  pixEn, hSync, vSync, rgbIn,
    output x, y, pixel, pixValid, frameStart, locked, timingErr, errCount
  );
endinterface

// File: rtl/vga_sync_receiver.sv
// VGA sink: samples sync/RGB on each pixel strobe, recovers x/y, locks to the
// incoming timing and flags/counts timing violations while locked.
module vga_sync_receiver #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int LOCK_LINES = 2
) (
  input  logic               clk,
  input  logic               reset,
  vga_sync_receiver_if.slave vga
);
  localparam int         H_TOTAL  = H_SYNC + H_BP + WIDTH + H_FP;
  localparam int         V_TOTAL  = V_SYNC + V_BP + HEIGHT + V_FP;
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT_LO = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_ACT_HI = 10'(H_SYNC + H_BP + WIDTH - 1);
  localparam logic [9:0] V_ACT_LO = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_ACT_HI = 10'(V_SYNC + V_BP + HEIGHT - 1);
  localparam logic [9:0] CNT_MAX  = 10'h3FF;
  localparam logic [3:0] LOCK_TGT = 4'(LOCK_LINES);

  typedef enum logic [1:0] {SEARCH = 2'd0, HLOCK = 2'd1, LOCKED = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [9:0]  hcount_q, hcount_d, vcount_q, vcount_d;
  logic        hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic [3:0]  good_q, good_d;
  logic [9:0]  x_q, x_d;
  logic [8:0]  y_q, y_d;
  logic [11:0] pixel_q, pixel_d;
  logic        pix_valid_q, pix_valid_d, frame_start_q, frame_start_d;
  logic        locked_q, locked_d, timing_err_q, timing_err_d;
  logic [15:0] err_count_q, err_count_d;

  logic       h_fall_s, v_fall_s, line_ok_s, h_err_s, v_err_s, err_s, active_s;
  logic [3:0] good_next_s;

  assign h_fall_s  = vga.pixEn & hs_prev_q & ~vga.hSync;
  assign v_fall_s  = h_fall_s & vs_prev_q & ~vga.vSync;
  assign line_ok_s = h_fall_s & (hcount_q == H_LAST);
  // A line is wrong if its edge arrives off-length, or no edge arrives by H_TOTAL.
  assign h_err_s   = vga.pixEn & (h_fall_s ? (hcount_q != H_LAST) : (hcount_q == H_LAST));
  assign v_err_s   = h_fall_s & (v_fall_s ? (vcount_q != V_LAST) : (vcount_q == V_LAST));
  assign err_s     = (state_q == LOCKED) & (h_err_s | v_err_s);
  assign good_next_s = line_ok_s ? ((good_q >= LOCK_TGT) ? good_q : good_q + 4'd1) : 4'd0;
  assign active_s  = (hcount_d >= H_ACT_LO) && (hcount_d <= H_ACT_HI) &&
                     (vcount_d >= V_ACT_LO) && (vcount_d <= V_ACT_HI);

  // Pixel/line counters and sync edge history; vSync is only looked at on line edges.
  always_comb begin
    hcount_d  = hcount_q;
    vcount_d  = vcount_q;
    hs_prev_d = hs_prev_q;
    vs_prev_d = vs_prev_q;
    if (vga.pixEn) begin
      hs_prev_d = vga.hSync;
      if (h_fall_s) begin
        hcount_d  = 10'd0;
        vs_prev_d = vga.vSync;
        if (v_fall_s) begin
          vcount_d = 10'd0;
        end else if (vcount_q != CNT_MAX) begin
          vcount_d = vcount_q + 10'd1;
        end else begin
          vcount_d = vcount_q;
        end
      end else if (hcount_q != CNT_MAX) begin
        hcount_d = hcount_q + 10'd1;
      end else begin
        hcount_d = hcount_q;
      end
    end else begin
      hs_prev_d = hs_prev_q;
    end
  end

  // Lock state machine: the line check on an edge is applied before its vSync check.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    case (state_q)
      SEARCH: begin
        if (h_fall_s) begin
          state_d = HLOCK;
          good_d  = 4'd0;
        end else begin
          state_d = SEARCH;
        end
      end
      HLOCK: begin
        if (h_fall_s) begin
          good_d = good_next_s;
          if (v_fall_s && (good_next_s >= LOCK_TGT)) begin
            state_d = LOCKED;
          end else begin
            state_d = HLOCK;
          end
        end else begin
          state_d = HLOCK;
        end
      end
      LOCKED: begin
        if (err_s) begin
          state_d = SEARCH;
        end else begin
          state_d = LOCKED;
        end
      end
      default: begin
        state_d = SEARCH;
        good_d  = 4'd0;
      end
    endcase
  end

  // Output stage: x/y/pixel hold their last valid value between valid pulses.
  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    pixel_d       = pixel_q;
    pix_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    timing_err_d  = err_s;
    locked_d      = (state_d == LOCKED);
    if (vga.pixEn && (state_q == LOCKED) && !err_s && active_s) begin
      pix_valid_d   = 1'b1;
      x_d           = hcount_d - H_ACT_LO;
      y_d           = 9'(vcount_d - V_ACT_LO);
      pixel_d       = vga.rgbIn;
      frame_start_d = (hcount_d == H_ACT_LO) && (vcount_d == V_ACT_LO);
    end else begin
      pix_valid_d   = 1'b0;
    end
    if (err_s && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end else begin
      err_count_d = err_count_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= SEARCH;
      hcount_q      <= 10'd0;
      vcount_q      <= 10'd0;
      hs_prev_q     <= 1'b1;
      vs_prev_q     <= 1'b1;
      good_q        <= 4'd0;
      x_q           <= 10'd0;
      y_q           <= 9'd0;
      pixel_q       <= 12'd0;
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      timing_err_q  <= 1'b0;
      err_count_q   <= 16'd0;
    end else begin
      state_q       <= state_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hs_prev_q     <= hs_prev_d;
      vs_prev_q     <= vs_prev_d;
      good_q        <= good_d;
      x_q           <= x_d;
      y_q           <= y_d;
      pixel_q       <= pixel_d;
      pix_valid_q   <= pix_valid_d;
      frame_start_q <= frame_start_d;
      locked_q      <= locked_d;
      timing_err_q  <= timing_err_d;
      err_count_q   <= err_count_d;
    end
  end

  assign vga.x          = x_q;
  assign vga.y          = y_q;
  assign vga.pixel      = pixel_q;
  assign vga.pixValid   = pix_valid_q;
  assign vga.frameStart = frame_start_q;
  assign vga.locked     = locked_q;
  assign vga.timingErr  = timing_err_q;
  assign vga.errCount   = err_count_q;
endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver on a shrunken raster (16x16 active, 25x21 total)
// against a line/frame-length reference model.
module tb_vga_sync_receiver;
  localparam int W = 16, H = 16, HFP = 2, HSY = 4, HBP = 3, VFP = 1, VSY = 2, VBP = 2, LL = 2;
  localparam int HT = HSY + HBP + W + HFP;
  localparam int VT = VSY + VBP + H + VFP;
  localparam int HA = HSY + HBP;
  localparam int VA = VSY + VBP;
  localparam int S_SEARCH = 0, S_HLOCK = 1, S_LOCKED = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  vga_sync_receiver_if bus();

  vga_sync_receiver #(
    .WIDTH(W), .HEIGHT(H), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .LOCK_LINES(LL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .vga(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0, test_no = 0;
  int gen_l = 0;
  int obs_pv = 0, obs_fs = 0, obs_te = 0;

  // reference model state
  int m_state, m_hc, m_vc, m_good;
  bit m_phs, m_pvs;
  int e_x, e_y, e_pix, e_ec;
  bit e_pv, e_fs, e_lk, e_te;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s (test %0d): got 0x%0h, expected 0x%0h", tag, test_no, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = S_SEARCH; m_hc = 0; m_vc = 0; m_good = 0; m_phs = 1'b1; m_pvs = 1'b1;
    e_x = 0; e_y = 0; e_pix = 0; e_ec = 0; e_pv = 0; e_fs = 0; e_lk = 0; e_te = 0;
  endtask

  task automatic model_idle();
    e_pv = 0; e_fs = 0; e_te = 0;
  endtask

  // One sampled pixel: judge the finished line/frame by its length, then advance.
  task automatic model_step(input bit hs, input bit vs, input logic [11:0] rgb);
    bit hfall, vfall, err, was_locked;
    int line_len, frame_len;
    hfall = m_phs && !hs;
    vfall = hfall && m_pvs && !vs;
    line_len = m_hc + 1;
    frame_len = m_vc + 1;
    was_locked = (m_state == S_LOCKED);
    err = 0;
    if (was_locked) begin
      if (hfall && line_len != HT) err = 1;
      if (!hfall && line_len == HT) err = 1;
      if (hfall && vfall && frame_len != VT) err = 1;
      if (hfall && !vfall && frame_len == VT) err = 1;
    end
    case (m_state)
      S_SEARCH: if (hfall) begin m_state = S_HLOCK; m_good = 0; end
      S_HLOCK: if (hfall) begin
        m_good = (line_len == HT) ? m_good + 1 : 0;
        if (vfall && m_good >= LL) m_state = S_LOCKED;
      end
      default: if (err) m_state = S_SEARCH;
    endcase
    if (hfall) begin
      m_hc = 0;
      m_vc = vfall ? 0 : ((m_vc + 1 > 1023) ? 1023 : m_vc + 1);
      m_pvs = vs;
    end else begin
      m_hc = (m_hc + 1 > 1023) ? 1023 : m_hc + 1;
    end
    m_phs = hs;
    e_pv = was_locked && !err && m_hc >= HA && m_hc < HA + W && m_vc >= VA && m_vc < VA + H;
    e_fs = 0;
    if (e_pv) begin
      e_x = m_hc - HA; e_y = m_vc - VA; e_pix = rgb;
      e_fs = (e_x == 0) && (e_y == 0);
    end
    e_te = err;
    if (err && e_ec < 65535) e_ec++;
    e_lk = (m_state == S_LOCKED);
  endtask

  task automatic check_all(input string ph);
    check_eq({ph, ".pixValid"},   32'(bus.pixValid),   32'(e_pv));
    check_eq({ph, ".frameStart"}, 32'(bus.frameStart), 32'(e_fs));
    check_eq({ph, ".locked"},     32'(bus.locked),     32'(e_lk));
    check_eq({ph, ".timingErr"},  32'(bus.timingErr),  32'(e_te));
    check_eq({ph, ".errCount"},   32'(bus.errCount),   32'(e_ec));
    check_eq({ph, ".x"},          32'(bus.x),          32'(e_x));
    check_eq({ph, ".y"},          32'(bus.y),          32'(e_y));
    check_eq({ph, ".pixel"},      32'(bus.pixel),      32'(e_pix));
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1; bus.pixEn = 1'b0;
    repeat (n) @(posedge clk);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    check_all("rst");
  endtask

  // One strobe slot of 4 clks: strobe on the first, checks on the next two.
  task automatic pix_slot(input bit hs, input bit vs, input logic [11:0] rgb);
    @(negedge clk);
    bus.pixEn = 1'b1; bus.hSync = hs; bus.vSync = vs; bus.rgbIn = rgb;
    @(posedge clk);
    model_step(hs, vs, rgb);
    @(negedge clk);
    bus.pixEn = 1'b0;
    check_all("pix");
    if (bus.pixValid) obs_pv++;
    if (bus.frameStart) obs_fs++;
    if (bus.timingErr) obs_te++;
    @(negedge clk);
    model_idle();
    check_all("idle");
    @(negedge clk);
  endtask

  task automatic pause_pixen(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.hSync = 1'($urandom); bus.vSync = 1'($urandom); bus.rgbIn = 12'($urandom);
      model_idle();
      check_all("pause");
    end
  endtask

  task automatic gen_line(input int len, input int flen, input int pause_at);
    bit hs, vs;
    logic [11:0] rgb;
    logic [9:0] xv, yv;
    for (int p = 0; p < len; p++) begin
      if (p == pause_at) pause_pixen(100);
      hs = (p >= HSY);
      vs = (gen_l >= VSY);
      if (p >= HA && p < HA + W && gen_l >= VA && gen_l < VA + H) begin
        xv = 10'(p - HA); yv = 10'(gen_l - VA);
        rgb = {xv[3:0], yv[3:0], 4'hA};
      end else begin
        rgb = 12'($urandom);
      end
      pix_slot(hs, vs, rgb);
    end
    gen_l = (gen_l + 1) % flen;
  endtask

  task automatic run_lines(input int n, input int flen, input int short_at, input int pause_at);
    int len, pz;
    for (int i = 0; i < n; i++) begin
      len = (gen_l == short_at) ? HT - 1 : HT;
      pz = (gen_l == pause_at) ? 12 : -1;
      gen_line(len, flen, pz);
    end
  endtask

  initial begin
    bus.pixEn = 1'b0; bus.hSync = 1'b1; bus.vSync = 1'b1; bus.rgbIn = 12'd0;
    do_reset(3);

    // ideal stream: acquire lock, then one fully locked frame
    test_no = 1;
    run_lines(VT, VT, -1, -1);
    obs_pv = 0; obs_fs = 0;
    run_lines(VT, VT, -1, -1);
    check_eq("t1.pixValidCount", 32'(obs_pv), 32'(W * H));
    check_eq("t1.frameStartCount", 32'(obs_fs), 32'd1);
    check_eq("t1.lastPixel", 32'(bus.pixel), 32'h0FFA);
    check_eq("t1.lastX", 32'(bus.x), 32'(W - 1));
    check_eq("t1.lastY", 32'(bus.y), 32'(H - 1));
    check_eq("t1.errCount", 32'(bus.errCount), 32'd0);
    check_eq("t1.locked", 32'(bus.locked), 32'd1);

    // one short line while locked, relock at next frame
    test_no = 2;
    obs_te = 0;
    run_lines(VT, VT, 5, -1);
    check_eq("t2.errPulses", 32'(obs_te), 32'd1);
    check_eq("t2.errCount", 32'(bus.errCount), 32'd1);
    check_eq("t2.lockedLost", 32'(bus.locked), 32'd0);
    obs_pv = 0;
    run_lines(VT, VT, -1, -1);
    check_eq("t2.relocked", 32'(bus.locked), 32'd1);
    check_eq("t2.pixValidCount", 32'(obs_pv), 32'(W * H));

    // reset mid-frame
    test_no = 3;
    run_lines(10, VT, -1, -1);
    do_reset(1);
    check_eq("t3.errCountCleared", 32'(bus.errCount), 32'd0);
    obs_pv = 0;
    run_lines(VT - 10, VT, -1, -1);
    check_eq("t3.noPixValid", 32'(obs_pv), 32'd0);
    run_lines(VT, VT, -1, -1);
    check_eq("t3.relocked", 32'(bus.locked), 32'd1);

    // hSync stuck high while locked
    test_no = 4;
    run_lines(4, VT, -1, -1);
    obs_te = 0;
    for (int i = 0; i < 2000; i++) pix_slot(1'b1, 1'b1, 12'($urandom));
    check_eq("t4.errPulses", 32'(obs_te), 32'd1);
    check_eq("t4.hcountSat", 32'(dut.hcount_q), 32'd1023);
    check_eq("t4.locked", 32'(bus.locked), 32'd0);
    gen_l = 0;
    run_lines(2 * VT, VT, -1, -1);
    check_eq("t4.relocked", 32'(bus.locked), 32'd1);

    // frame one line short while locked
    test_no = 5;
    obs_te = 0;
    run_lines(VT - 1, VT - 1, -1, -1);
    run_lines(VT, VT, -1, -1);
    check_eq("t5.errPulses", 32'(obs_te), 32'd1);
    check_eq("t5.errCount", 32'(bus.errCount), 32'd2);

    // strobe pause mid-line with toggling inputs
    test_no = 6;
    obs_pv = 0; obs_fs = 0;
    run_lines(VT, VT, -1, 8);
    check_eq("t6.pixValidCount", 32'(obs_pv), 32'(W * H));
    check_eq("t6.frameStartCount", 32'(obs_fs), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
